// File: rtl/mult8x8_ctrl.sv
// mult8x8_ctrl: sequencing FSM for an 8x8 shift-and-add multiplier built from 4x4 partial products
module mult8x8_ctrl #(
  parameter bit IDLE_CLR = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic [1:0] input_sel,
  output logic [1:0] shift_sel,
  output logic       clk_ena,
  output logic       sclr_n,
  output logic       busy,
  output logic       done_flag,
  output logic       err_flag,
  output logic [2:0] state_out
);
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    LSB  = 3'd2,
    MID  = 3'd3,
    MSB  = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;
  state_t state_q, state_d;
  logic   cnt_q, cnt_d;
  logic   done_q, done_d;
  logic   err_q, err_d;
  logic   accept;
  // state register, MID cycle counter and sticky status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  // next state; start seen while accumulating aborts to ERR, unused codes recover to IDLE
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = start ? (IDLE_CLR ? CLR : LSB) : IDLE;
      CLR:     state_d = LSB;
      LSB:     state_d = start ? ERR : MID;
      MID:     state_d = start ? ERR : (cnt_q ? MSB : MID);
      MSB:     state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = start ? ERR : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // counter steps through the two MID cycles; flags clear on an accepted start
  always_comb begin
    accept = (state_q == IDLE) && start;
    cnt_d  = (state_q == MID) ? ~cnt_q : ((state_q == LSB) ? 1'b0 : cnt_q);
    done_d = accept ? 1'b0 : ((state_q == MSB) ? 1'b1 : done_q);
    err_d  = accept ? 1'b0 : (((state_q == LSB) || (state_q == MID)) && start ? 1'b1 : err_q);
  end
  // Moore decode of datapath controls from the current state
  always_comb begin
    input_sel = (state_q == MID) ? (cnt_q ? 2'b10 : 2'b01) : ((state_q == MSB) ? 2'b11 : 2'b00);
    shift_sel = (state_q == MID) ? 2'b01 : ((state_q == MSB) ? 2'b10 : 2'b00);
    busy      = (state_q == CLR) || (state_q == LSB) || (state_q == MID) || (state_q == MSB);
    clk_ena   = busy;
    sclr_n    = state_q != CLR;
  end
  assign done_flag = done_q;
  assign err_flag  = err_q;
  assign state_out = state_q;
endmodule

// File: tb/tb_mult8x8_ctrl.sv
// tb_mult8x8_ctrl: randomized self-checking bench for both CLR and MAC variants of the controller
module tb_mult8x8_ctrl;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       start1, start0;
  logic [1:0] input_sel1, shift_sel1, input_sel0, shift_sel0;
  logic       clk_ena1, sclr_n1, busy1, done_flag1, err_flag1;
  logic       clk_ena0, sclr_n0, busy0, done_flag0, err_flag0;
  logic [2:0] state_out1, state_out0;
  logic [7:0] a, b;
  logic [15:0] acc1 = '0, acc0 = '0, pre_val = '0;
  logic       pre0 = 1'b0;
  logic [8:0] tup1, tup0;
  int n_checks = 0, n_fail = 0;
  logic [8:0] seq1 [5] = '{{3'd1, 2'b00, 2'b00, 1'b1, 1'b0}, {3'd2, 2'b00, 2'b00, 1'b1, 1'b1},
                           {3'd3, 2'b01, 2'b01, 1'b1, 1'b1}, {3'd3, 2'b10, 2'b01, 1'b1, 1'b1},
                           {3'd4, 2'b11, 2'b10, 1'b1, 1'b1}};
  logic [8:0] seq0 [4] = '{{3'd2, 2'b00, 2'b00, 1'b1, 1'b1}, {3'd3, 2'b01, 2'b01, 1'b1, 1'b1},
                           {3'd3, 2'b10, 2'b01, 1'b1, 1'b1}, {3'd4, 2'b11, 2'b10, 1'b1, 1'b1}};

  always #5 clk = ~clk;

  mult8x8_ctrl #(.IDLE_CLR(1'b1)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .input_sel(input_sel1), .shift_sel(shift_sel1),
    .clk_ena(clk_ena1), .sclr_n(sclr_n1), .busy(busy1), .done_flag(done_flag1), .err_flag(err_flag1),
    .state_out(state_out1));
  mult8x8_ctrl #(.IDLE_CLR(1'b0)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .input_sel(input_sel0), .shift_sel(shift_sel0),
    .clk_ena(clk_ena0), .sclr_n(sclr_n0), .busy(busy0), .done_flag(done_flag0), .err_flag(err_flag0),
    .state_out(state_out0));

  assign tup1 = {state_out1, input_sel1, shift_sel1, clk_ena1, sclr_n1};
  assign tup0 = {state_out0, input_sel0, shift_sel0, clk_ena0, sclr_n0};

  // 4x4 multiplier plus shifter feeding the accumulator
  function automatic logic [15:0] pp(input logic [1:0] is, input logic [1:0] sh, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    p = {12'b0, (is[1] ? x[7:4] : x[3:0])} * {12'b0, (is[0] ? y[7:4] : y[3:0])};
    return (sh == 2'b01) ? p << 4 : ((sh == 2'b10) ? p << 8 : p);
  endfunction

  // accumulator registers downstream of the adder
  always @(posedge clk) begin
    if (clk_ena1) acc1 <= !sclr_n1 ? 16'h0 : acc1 + pp(input_sel1, shift_sel1, a, b);
    if (pre0) acc0 <= pre_val;
    else if (clk_ena0) acc0 <= !sclr_n0 ? 16'h0 : acc0 + pp(input_sel0, shift_sel0, a, b);
  end

  task automatic pulse1();
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
  endtask

  task automatic pulse0();
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
  endtask

  task automatic wait_done1(output int k);
    k = 0;
    while (!done_flag1 && k < 12) begin @(negedge clk); k++; end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start1 = 1'b0; start0 = 1'b0; a = '0; b = '0;
    #1;
    n_checks++; if (state_out1 !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", state_out1); end
    n_checks++; if (clk_ena1 !== 1'b0) begin n_fail++; $display("FAIL reset_clk_ena got %b exp 0", clk_ena1); end
    n_checks++; if (sclr_n1 !== 1'b1) begin n_fail++; $display("FAIL reset_sclr_n got %b exp 1", sclr_n1); end
    n_checks++; if ({done_flag1, err_flag1, busy1} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {done_flag1, err_flag1, busy1}); end
    n_checks++; if ({input_sel1, shift_sel1} !== 4'b0000) begin n_fail++; $display("FAIL reset_sel got %b exp 0000", {input_sel1, shift_sel1}); end
    n_checks++; if (tup0 !== 9'b000_00_00_0_1) begin n_fail++; $display("FAIL reset_mac_tuple got %b exp 000000001", tup0); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_nominal();
    a = 8'($urandom); b = 8'($urandom);
    pulse1();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (tup1 !== seq1[i] || busy1 !== 1'b1) begin n_fail++; $display("FAIL nominal_step%0d got %b/%b exp %b/1", i, tup1, busy1, seq1[i]); end
      @(negedge clk);
    end
    n_checks++; if ({state_out1, clk_ena1, busy1, done_flag1} !== {3'd5, 3'b001}) begin n_fail++; $display("FAIL nominal_done got %b exp 101001", {state_out1, clk_ena1, busy1, done_flag1}); end
    @(negedge clk);
    n_checks++; if ({state_out1, done_flag1} !== {3'd0, 1'b1}) begin n_fail++; $display("FAIL nominal_idle got %b exp 0001", {state_out1, done_flag1}); end
    n_checks++; if (acc1 !== a * b) begin n_fail++; $display("FAIL nominal_product got %h exp %h", acc1, 16'(a * b)); end
  endtask

  task automatic test_datapath();
    logic [7:0] av [6] = '{8'hFF, 8'hA5, 8'h00, 8'h01, 8'h80, 8'h5A};
    logic [7:0] bv [6] = '{8'hFF, 8'h3C, 8'h77, 8'hFF, 8'h80, 8'h00};
    int k;
    for (int i = 0; i < 10; i++) begin
      a = (i < 6) ? av[i] : 8'($urandom); b = (i < 6) ? bv[i] : 8'($urandom);
      pulse1();
      wait_done1(k);
      n_checks++; if (k !== 5) begin n_fail++; $display("FAIL datapath_latency%0d got %0d exp 5", i, k); end
      n_checks++; if (acc1 !== a * b) begin n_fail++; $display("FAIL datapath_product%0d a=%h b=%h got %h exp %h", i, a, b, acc1, 16'(a * b)); end
    end
    @(negedge clk);
  endtask

  task automatic test_mac();
    int k;
    logic seen_clr;
    for (int i = 0; i < 4; i++) begin
      pre_val = (i == 0) ? 16'd100 : 16'($urandom);
      a = (i == 0) ? 8'd3 : 8'($urandom); b = (i == 0) ? 8'd4 : 8'($urandom);
      @(negedge clk); pre0 = 1'b1;
      @(negedge clk); pre0 = 1'b0;
      pulse0();
      k = 0; seen_clr = 1'b0;
      while (!done_flag0 && k < 12) begin
        if (state_out0 == 3'd1) seen_clr = 1'b1;
        if (k < 4) begin
          n_checks++; if (tup0 !== seq0[k]) begin n_fail++; $display("FAIL mac%0d_step%0d got %b exp %b", i, k, tup0, seq0[k]); end
        end
        @(negedge clk); k++;
      end
      n_checks++; if (k !== 4 || seen_clr) begin n_fail++; $display("FAIL mac%0d_latency got %0d clr=%b exp 4 clr=0", i, k, seen_clr); end
      n_checks++; if (acc0 !== 16'(pre_val + a * b)) begin n_fail++; $display("FAIL mac%0d_sum got %h exp %h", i, acc0, 16'(pre_val + a * b)); end
      @(negedge clk);
    end
  endtask

  task automatic test_error();
    int k;
    logic [15:0] part;
    for (int p = 1; p <= 3; p++) begin
      a = 8'($urandom); b = 8'($urandom);
      part = 16'(a[3:0] * b[3:0]);
      if (p >= 2) part = part + 16'(16'(a[3:0] * b[7:4]) << 4);
      if (p >= 3) part = part + 16'(16'(a[7:4] * b[3:0]) << 4);
      pulse1();
      for (int i = 0; i < p; i++) @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      n_checks++; if ({state_out1, clk_ena1, busy1, err_flag1} !== {3'd6, 3'b001}) begin n_fail++; $display("FAIL err%0d_entry got %b exp 110001", p, {state_out1, clk_ena1, busy1, err_flag1}); end
      n_checks++; if (acc1 !== part) begin n_fail++; $display("FAIL err%0d_partial got %h exp %h", p, acc1, part); end
      @(negedge clk);
      n_checks++; if (state_out1 !== 3'd6) begin n_fail++; $display("FAIL err%0d_hold got %0d exp 6", p, state_out1); end
      start1 = 1'b0;
      @(negedge clk);
      n_checks++; if ({state_out1, err_flag1} !== {3'd0, 1'b1}) begin n_fail++; $display("FAIL err%0d_exit got %b exp 0001", p, {state_out1, err_flag1}); end
      pulse1();
      n_checks++; if ({state_out1, err_flag1} !== {3'd1, 1'b0}) begin n_fail++; $display("FAIL err%0d_clear got %b exp 0010", p, {state_out1, err_flag1}); end
      wait_done1(k);
      n_checks++; if (acc1 !== a * b || k !== 5) begin n_fail++; $display("FAIL err%0d_recover got %h/%0d exp %h/5", p, acc1, k, 16'(a * b)); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    a = 8'($urandom); b = 8'($urandom);
    @(negedge clk); start1 = 1'b1;
    @(negedge clk);
    @(negedge clk); start1 = 1'b0;
    n_checks++; if (state_out1 !== 3'd2) begin n_fail++; $display("FAIL clr_ignore got %0d exp 2", state_out1); end
    wait_done1(k);
    n_checks++; if (acc1 !== a * b || err_flag1 !== 1'b0) begin n_fail++; $display("FAIL clr_ignore_result got %h/%b exp %h/0", acc1, err_flag1, 16'(a * b)); end
    @(negedge clk); start1 = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    n_checks++; if ({state_out1, err_flag1} !== {3'd6, 1'b1}) begin n_fail++; $display("FAIL held_start got %b exp 1101", {state_out1, err_flag1}); end
    start1 = 1'b0;
    @(negedge clk);
    a = 8'($urandom); b = 8'($urandom);
    pulse1();
    wait_done1(k);
    @(negedge clk);
    pulse1();
    n_checks++; if ({state_out1, done_flag1} !== {3'd1, 1'b0}) begin n_fail++; $display("FAIL done_clear got %b exp 0010", {state_out1, done_flag1}); end
    wait_done1(k);
    n_checks++; if (acc1 !== a * b || k !== 5) begin n_fail++; $display("FAIL back_to_back got %h/%0d exp %h/5", acc1, k, 16'(a * b)); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int k;
    a = 8'($urandom); b = 8'($urandom);
    pulse1();
    @(negedge clk); @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    n_checks++; if ({state_out1, clk_ena1, done_flag1, err_flag1} !== 6'b000000) begin n_fail++; $display("FAIL async_reset got %b exp 000000", {state_out1, clk_ena1, done_flag1, err_flag1}); end
    #1 reset_n = 1'b1;
    a = 8'($urandom); b = 8'($urandom);
    pulse1();
    wait_done1(k);
    n_checks++; if (acc1 !== a * b || k !== 5) begin n_fail++; $display("FAIL async_restart got %h/%0d exp %h/5", acc1, k, 16'(a * b)); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_datapath();
    test_mac();
    test_error();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mult8x8_ctrl.md
Name: mult8x8_ctrl

Overview:
Sequencing FSM for the 8x8 shift-and-add multiplier. It drives the 4x4 partial-product operand select, the shifter select, and the clk_ena/sclr_n controls of the 16-bit accumulator register that sits directly downstream of the adder.
One multiply takes four accumulate cycles: lo*lo, lo*hi, hi*lo, hi*hi. It also reports busy, done and error status, plus a state code for seven-segment debug display.

Parameters:
IDLE_CLR, 1, 1: emit one CLR cycle (clk_ena=1, sclr_n=0) before the LSB cycle; 0: skip CLR so the product accumulates onto the prior register contents (MAC mode).

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  level request to begin a multiply; sampled on rising clk
input_sel  output  2  partial product select: 00 a_lo*b_lo, 01 a_lo*b_hi, 10 a_hi*b_lo, 11 a_hi*b_hi
shift_sel  output  2  shifter select: 00 <<0, 01 <<4, 10 <<8, 11 unused (never driven)
clk_ena  output  1  accumulator clock enable
sclr_n  output  1  accumulator synchronous clear, active-low
busy  output  1  high in CLR, LSB, MID, MSB
done_flag  output  1  registered; product valid in accumulator
err_flag  output  1  registered; start re-asserted mid-operation
state_out  output  3  state code: IDLE=0, CLR=1, LSB=2, MID=3, MSB=4, DONE=5, ERR=6

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, mid counter=0, done_flag=0, err_flag=0. Outputs then read input_sel=00, shift_sel=00, clk_ena=0, sclr_n=1, busy=0, state_out=0.
- input_sel, shift_sel, clk_ena, sclr_n, busy and state_out are Moore outputs decoded from the current state (plus the mid counter in MID).
- IDLE: clk_ena=0, sclr_n=1.
  - start=1 at an edge -> CLR if IDLE_CLR=1, else LSB.
  - done_flag and err_flag clear on that same edge.
  - start=0 -> stay in IDLE.
- CLR: clk_ena=1, sclr_n=0, sel=00, shift=00; -> LSB unconditionally.
- LSB: clk_ena=1, sclr_n=1, input_sel=00, shift_sel=00; mid counter cleared to 0.
- MID: clk_ena=1, sclr_n=1, shift_sel=01; input_sel=01 when counter=0, 10 when counter=1.
  - Counter increments each MID cycle.
  - -> MSB on the edge where counter=1; counter then returns to 0.
- MSB: clk_ena=1, sclr_n=1, input_sel=11, shift_sel=10; -> DONE.
- Transitions LSB->MID and MID->MSB occur only when start=0.
- DONE: clk_ena=0; done_flag set on the edge entering DONE.
  - -> IDLE on the next edge regardless of start.
  - done_flag stays high in IDLE until the next start is accepted.
- Latency, IDLE_CLR=1: start sampled at edge E0.
  - Accumulator clears at E1, then accumulates at E2, E3, E4 and E5.
  - done_flag=1 after E5; product is stable in the accumulator from E5.
- Latency, IDLE_CLR=0: every step is one cycle earlier; done_flag=1 after E4.
- Error: start=1 sampled in LSB or MID (either counter value) -> ERR.
  - The accumulate already enabled in that cycle still occurs.
  - err_flag set on entry to ERR.
  - start sampled in CLR or MSB is ignored.
- ERR: clk_ena=0, sclr_n=1; stay while start=1; -> IDLE when start=0.
  - err_flag stays high until the next start is accepted in IDLE.
- start held high through a whole operation is an error (detected in LSB). The intended protocol is to pulse start for exactly one cycle.
- Reset mid-operation: immediate return to IDLE with all flags cleared. The accumulator contents are undefined and the user must restart.
- Unused state encodings (7) -> IDLE on the next edge.

Test Plan:
- Reset: hold reset_n=0 with no clock edge -> state_out=0, clk_ena=0, sclr_n=1, done_flag=0, err_flag=0, busy=0.
- Nominal, IDLE_CLR=1, one-cycle start pulse -> per cycle, as (state_out, input_sel, shift_sel, clk_ena, sclr_n):
  - CLR (1, 00, 00, 1, 0)
  - LSB (2, 00, 00, 1, 1)
  - MID (3, 01, 01, 1, 1)
  - MID (3, 10, 01, 1, 1)
  - MSB (4, 11, 10, 1, 1)
  - DONE (5, clk_ena=0), then IDLE with done_flag=1.
- Full datapath with the accumulator register, a=8'hFF, b=8'hFF -> accumulator reads 16'hFE01 when done_flag rises.
  - Repeat with a=8'hA5, b=8'h3C -> 16'h26AC.
- IDLE_CLR=0, accumulator preloaded with 16'd100, a=8'd3, b=8'd4 -> accumulator=16'd112. Sequence has no CLR state and is one cycle shorter.
- start=1 re-asserted in the second MID cycle -> ERR (state_out=6) with clk_ena=0, err_flag=1.
  - ERR held while start=1; returns to IDLE one edge after start=0.
  - err_flag cleared by the next accepted start.
- reset_n pulsed low during MID, asynchronously between edges -> state_out=0 and clk_ena=0 immediately; a new start then completes normally.
